// File: rtl/ram_pkg.sv
// Shared constants and types for the 4-write / 1-read LVT RAM.
package ram_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_WPORTS = 4;

    // Bank selector stored in each LVT entry: value n-1 means write port n.
    typedef logic [1:0] lvt_idx_t;

    // Address width for a given BLOCKSIZE.
    function automatic int unsigned addr_w(input int unsigned blocksize);
        return blocksize + 1;
    endfunction

endpackage

// File: rtl/lvt_4w1r.sv
// Live Value Table: remembers which write port last wrote each address,
// with a registered read and a registered same-address write conflict flag.
module lvt_4w1r
    import ram_pkg::*;
#(
    parameter  int unsigned BLOCKSIZE = 10,
    localparam int unsigned AW        = addr_w(BLOCKSIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] w_addr_1,
    input  logic [AW-1:0] w_addr_2,
    input  logic [AW-1:0] w_addr_3,
    input  logic [AW-1:0] w_addr_4,
    input  logic          w_enb_1,
    input  logic          w_enb_2,
    input  logic          w_enb_3,
    input  logic          w_enb_4,
    input  logic [AW-1:0] r_addr,
    output lvt_idx_t      r_sel,
    output logic          w_conflict
);

    lvt_idx_t      lvt [2**AW];
    logic [AW-1:0] addr [NUM_WPORTS];
    logic          enb  [NUM_WPORTS];
    logic          conflict;

    // Gather the write ports into arrays and flag any shared enabled address.
    always_comb begin
        addr[0] = w_addr_1;
        addr[1] = w_addr_2;
        addr[2] = w_addr_3;
        addr[3] = w_addr_4;
        enb[0]  = w_enb_1;
        enb[1]  = w_enb_2;
        enb[2]  = w_enb_3;
        enb[3]  = w_enb_4;
        conflict = 1'b0;
        for (int unsigned i = 0; i < NUM_WPORTS; i++) begin
            for (int unsigned j = i + 1; j < NUM_WPORTS; j++) begin
                if (enb[i] && enb[j] && (addr[i] == addr[j])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Table update; later loop iterations override, so the highest port wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 2**AW; k++) begin
                lvt[k] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_WPORTS; i++) begin
                if (enb[i]) begin
                    lvt[addr[i]] <= lvt_idx_t'(i);
                end
            end
        end
    end

    // Registered read (pre-update entry) and one-cycle conflict pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel      <= '0;
            w_conflict <= 1'b0;
        end else begin
            r_sel      <= lvt[r_addr];
            w_conflict <= conflict;
        end
    end

endmodule

// File: rtl/ram_1R1W.sv
// Single-write, single-read RAM bank with registered, read-first read port.
module ram_1R1W
    import ram_pkg::*;
#(
    parameter  int unsigned BLOCKSIZE = 10,
    localparam int unsigned AW        = addr_w(BLOCKSIZE)
) (
    input  logic              clk,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_din,
    input  logic              w_enb,
    input  logic [AW-1:0]     r_addr,
    output logic [DATA_W-1:0] r_dout
);

    logic [DATA_W-1:0] mem [2**AW];

    // Write and registered read on the same edge; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (w_enb) begin
            mem[w_addr] <= w_din;
        end
        r_dout <= mem[r_addr];
    end

endmodule

// File: rtl/ram_1r4w_lvt.sv
// 4-write / 1-read RAM built from four 1R1W banks plus a Live Value Table.
// Read latency 2: stage 1 = bank/LVT read, stage 2 = select mux into r_dout_1.
// Optional macro RAM_1R4W_BYPASS_EN makes same-edge read-during-write write-first.
module ram_1r4w_lvt
    import ram_pkg::*;
#(
    parameter  int unsigned BLOCKSIZE = 10,
    localparam int unsigned AW        = addr_w(BLOCKSIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     w_addr_1,
    input  logic [AW-1:0]     w_addr_2,
    input  logic [AW-1:0]     w_addr_3,
    input  logic [AW-1:0]     w_addr_4,
    input  logic [DATA_W-1:0] w_din_1,
    input  logic [DATA_W-1:0] w_din_2,
    input  logic [DATA_W-1:0] w_din_3,
    input  logic [DATA_W-1:0] w_din_4,
    input  logic              w_enb_1,
    input  logic              w_enb_2,
    input  logic              w_enb_3,
    input  logic              w_enb_4,
    input  logic [AW-1:0]     r_addr_1,
    output logic [DATA_W-1:0] r_dout_1,
    output logic              w_conflict
);

    logic [DATA_W-1:0] bank_q [NUM_WPORTS];
    lvt_idx_t          sel;
    logic              s1_vld;
    logic              byp_hit_q;
    logic [DATA_W-1:0] byp_data_q;

    ram_1R1W #(.BLOCKSIZE(BLOCKSIZE)) u_bank_1 (
        .clk(clk), .w_addr(w_addr_1), .w_din(w_din_1), .w_enb(w_enb_1),
        .r_addr(r_addr_1), .r_dout(bank_q[0])
    );
    ram_1R1W #(.BLOCKSIZE(BLOCKSIZE)) u_bank_2 (
        .clk(clk), .w_addr(w_addr_2), .w_din(w_din_2), .w_enb(w_enb_2),
        .r_addr(r_addr_1), .r_dout(bank_q[1])
    );
    ram_1R1W #(.BLOCKSIZE(BLOCKSIZE)) u_bank_3 (
        .clk(clk), .w_addr(w_addr_3), .w_din(w_din_3), .w_enb(w_enb_3),
        .r_addr(r_addr_1), .r_dout(bank_q[2])
    );
    ram_1R1W #(.BLOCKSIZE(BLOCKSIZE)) u_bank_4 (
        .clk(clk), .w_addr(w_addr_4), .w_din(w_din_4), .w_enb(w_enb_4),
        .r_addr(r_addr_1), .r_dout(bank_q[3])
    );

    lvt_4w1r #(.BLOCKSIZE(BLOCKSIZE)) u_lvt (
        .clk(clk), .rst(rst),
        .w_addr_1(w_addr_1), .w_addr_2(w_addr_2),
        .w_addr_3(w_addr_3), .w_addr_4(w_addr_4),
        .w_enb_1(w_enb_1), .w_enb_2(w_enb_2),
        .w_enb_3(w_enb_3), .w_enb_4(w_enb_4),
        .r_addr(r_addr_1), .r_sel(sel), .w_conflict(w_conflict)
    );

`ifdef RAM_1R4W_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    // Match the read address against enabled writes; highest port checked last wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (w_enb_1 && (w_addr_1 == r_addr_1)) begin byp_hit = 1'b1; byp_data = w_din_1; end
        if (w_enb_2 && (w_addr_2 == r_addr_1)) begin byp_hit = 1'b1; byp_data = w_din_2; end
        if (w_enb_3 && (w_addr_3 == r_addr_1)) begin byp_hit = 1'b1; byp_data = w_din_3; end
        if (w_enb_4 && (w_addr_4 == r_addr_1)) begin byp_hit = 1'b1; byp_data = w_din_4; end
    end

    // Stage-1 capture of the forwarded write data alongside the bank read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= byp_hit;
            byp_data_q <= byp_data;
        end
    end
`else
    // Read-first build: no forwarding path.
    always_comb begin
        byp_hit_q  = 1'b0;
        byp_data_q = '0;
    end
`endif

    // Stage-1 valid: bank read registers are not reset, so the first
    // post-reset stage-2 load is forced to zero to discard in-flight reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= 1'b1;
        end
    end

    // Stage 2: select the live bank (or forwarded data) into the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_1 <= '0;
        end else if (!s1_vld) begin
            r_dout_1 <= '0;
        end else if (byp_hit_q) begin
            r_dout_1 <= byp_data_q;
        end else begin
            r_dout_1 <= bank_q[sel];
        end
    end

endmodule
